buscador_binario_8bits: RTL
===========================

Name: buscador_binario_8bits

Overview:
- Sequential binary-search engine that drives an external 8-bit magnitude comparator.
- It issues probe values, consumes the gt/eq/lt flags returned for each probe, and converges on the hidden 8-bit operand held by the comparator side.
- It sits on the initiator end of the comparator flag interface in the ALU datapath and is used for value discovery and self-test of the comparator.

Parameters:
- LARGURA, 8, operand width; the design is only required to work at 8.
- MAX_PASSOS, 9, probe limit, equal to floor(log2(2^LARGURA))+1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- inicio  input  1  start pulse; sampled only in OCIOSO.
- abortar  input  1  synchronous abort of a search in progress.
- sonda  output  8  probe value presented to the comparator.
- sonda_valida  output  1  probe valid; held until accepted.
- flag_valida  input  1  comparator response valid.
- cmp_gt  input  1  sonda > hidden operand.
- cmp_eq  input  1  sonda = hidden operand.
- cmp_lt  input  1  sonda < hidden operand.
- ocupado  output  1  high in SONDA or ATUALIZA.
- pronto  output  1  one-cycle completion pulse.
- encontrado  output  1  result valid flag; held until next inicio.
- erro  output  1  protocol/consistency error; held until next inicio.
- resultado  output  8  discovered value; held until next inicio.
- passos  output  4  number of probes accepted in the current/last search.

Behaviour:
- Reset, sampled at clk edge while rst_n=0, wins over everything:
  - state=OCIOSO.
  - sonda=0x00, sonda_valida=0, ocupado=0, pronto=0, encontrado=0, erro=0, resultado=0x00, passos=0.
  - internal lo=0, hi=255.
- State OCIOSO:
  - inicio=1 → lo=0, hi=255, passos=0, encontrado=0, erro=0, resultado=0x00.
  - Next state is SONDA.
- State SONDA:
  - sonda=(lo+hi)>>1, computed with a 9-bit sum; sonda_valida=1; sonda stays stable while in SONDA.
  - Handshake completes on the edge where sonda_valida=1 and flag_valida=1.
  - On completion: flags are latched, passos increments, next state is ATUALIZA.
  - With no flag_valida, stay in SONDA indefinitely; there is no timeout.
- State ATUALIZA:
  - sonda_valida=0. This gives at least one idle cycle between probes.
  - Exactly cmp_eq → resultado=sonda, encontrado=1, go to FIM.
  - Exactly cmp_gt:
    - If sonda==lo → erro=1, go to FIM.
    - Otherwise hi=sonda-1, go to SONDA.
  - Exactly cmp_lt:
    - If sonda==hi → erro=1, go to FIM.
    - Otherwise lo=sonda+1, go to SONDA.
  - Zero flags, or more than one flag set → erro=1, go to FIM.
  - passos reaching MAX_PASSOS without eq cannot occur with a consistent comparator. It is still checked: erro=1, go to FIM.
- State FIM:
  - pronto=1 for exactly this one cycle, then OCIOSO.
  - encontrado, erro, resultado and passos remain held.
- Output relations:
  - encontrado and erro are never both 1.
  - ocupado=1 exactly in SONDA and ATUALIZA.
- Abort:
  - abortar=1 in SONDA or ATUALIZA → next state OCIOSO, sonda_valida=0.
  - No pronto pulse; encontrado=0, erro=0.
  - abortar has priority over flag acceptance in the same cycle.
  - abortar in OCIOSO or FIM has no effect.
- inicio is ignored outside OCIOSO, including the FIM cycle.
- inicio and abortar together in OCIOSO: the search starts.
- Latency: inicio edge → first sonda_valida on the next cycle. Each probe costs (response wait + 2) cycles. pronto comes 1 cycle after the final ATUALIZA.
- Worst case is 9 probes (operand 0xFF); best case is 1 probe (operand 0x7F).

Test Plan:
- Hidden operand 0x7F, responder answers the same cycle → single probe 0x7F; encontrado=1, resultado=0x7F, passos=1, pronto pulses once.
- Hidden operand 0x00 → probes 0x7F,0x3F,0x1F,0x0F,0x07,0x03,0x01,0x00; resultado=0x00, passos=8.
- Hidden operand 0xFF, responder delays flag_valida 0–3 random cycles → probes 0x7F,0xBF,0xDF,0xEF,0xF7,0xFB,0xFD,0xFE,0xFF; passos=9; sonda stable while waiting.
- Responder returns cmp_gt=cmp_lt=1 on the first probe → erro=1, encontrado=0, passos=1, pronto pulses. A later response always claiming cmp_lt at 0xFF → erro=1.
- abortar asserted during the third probe's wait, same cycle as flag_valida → OCIOSO next cycle, no pronto, erro=0, encontrado=0. A new inicio then searches 0x42 correctly.
- rst_n=0 mid-search, plus inicio pulses during SONDA → all outputs at reset values the following cycle. Extra inicio pulses do not restart or disturb the search.

Source files
------------

// File: rtl/buscador_binario_8bits_if.sv
// rtl/buscador_binario_8bits_if.sv - probe/flag handshake between the search engine and the comparator
interface buscador_binario_8bits_if #(
  parameter int LARGURA = 8
);
  logic [LARGURA-1:0] sonda;
  logic               sonda_valida;
  logic               flag_valida;
  logic               cmp_gt;
  logic               cmp_eq;
  logic               cmp_lt;

  modport master (
    output sonda, sonda_valida,
    input  flag_valida, cmp_gt, cmp_eq, cmp_lt
  );

  modport slave (
    input  sonda, sonda_valida,
    output flag_valida, cmp_gt, cmp_eq, cmp_lt
  );
endinterface

// File: rtl/buscador_binario_8bits.sv
// rtl/buscador_binario_8bits.sv - binary-search engine that probes an external comparator
// and converges on its hidden operand
module buscador_binario_8bits #(
  parameter int LARGURA    = 8,
  parameter int MAX_PASSOS = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inicio,
  input  logic                  abortar,
  buscador_binario_8bits_if.master bus,
  output logic                  ocupado,
  output logic                  pronto,
  output logic                  encontrado,
  output logic                  erro,
  output logic [LARGURA-1:0]    resultado,
  output logic [3:0]            passos
);

  typedef enum logic [1:0] {OCIOSO, SONDA, ATUALIZA, FIM} estado_t;

  localparam logic [3:0]         PASSOS_MAX = 4'(MAX_PASSOS);
  localparam logic [LARGURA-1:0] UM         = {{(LARGURA-1){1'b0}}, 1'b1};

  estado_t            estado, estado_n;
  logic [LARGURA-1:0] lo, lo_n;
  logic [LARGURA-1:0] hi, hi_n;
  logic [LARGURA-1:0] sonda_r, sonda_n;
  logic [LARGURA-1:0] resultado_n;
  logic [3:0]         passos_n;
  logic               encontrado_n, erro_n;
  logic               f_gt, f_eq, f_lt;
  logic               f_gt_n, f_eq_n, f_lt_n;
  logic               um_so;

  // Midpoint with a carry bit so lo+hi never wraps.
  function automatic logic [LARGURA-1:0] meio(input logic [LARGURA-1:0] a,
                                              input logic [LARGURA-1:0] b);
    logic [LARGURA:0] soma;
    soma = {1'b0, a} + {1'b0, b};
    return LARGURA'(soma >> 1);
  endfunction

  assign um_so = (f_gt ^ f_eq ^ f_lt) && !(f_gt && f_eq && f_lt);

  always_comb begin
    estado_n     = estado;
    lo_n         = lo;
    hi_n         = hi;
    sonda_n      = sonda_r;
    resultado_n  = resultado;
    passos_n     = passos;
    encontrado_n = encontrado;
    erro_n       = erro;
    f_gt_n       = f_gt;
    f_eq_n       = f_eq;
    f_lt_n       = f_lt;

    case (estado)
      OCIOSO: begin
        if (inicio) begin
          lo_n         = '0;
          hi_n         = '1;
          sonda_n      = meio('0, '1);
          passos_n     = 4'd0;
          encontrado_n = 1'b0;
          erro_n       = 1'b0;
          resultado_n  = '0;
          estado_n     = SONDA;
        end
      end

      SONDA: begin
        if (abortar) begin
          encontrado_n = 1'b0;
          erro_n       = 1'b0;
          estado_n     = OCIOSO;
        end else if (bus.flag_valida) begin
          f_gt_n   = bus.cmp_gt;
          f_eq_n   = bus.cmp_eq;
          f_lt_n   = bus.cmp_lt;
          passos_n = passos + 4'd1;
          estado_n = ATUALIZA;
        end
      end

      ATUALIZA: begin
        if (abortar) begin
          encontrado_n = 1'b0;
          erro_n       = 1'b0;
          estado_n     = OCIOSO;
        end else if (f_eq && um_so) begin
          resultado_n  = sonda_r;
          encontrado_n = 1'b1;
          estado_n     = FIM;
        end else if (!um_so || passos >= PASSOS_MAX) begin
          erro_n   = 1'b1;
          estado_n = FIM;
        end else if (f_gt) begin
          // A "greater" answer at the lower bound means the comparator contradicted itself.
          if (sonda_r == lo) begin
            erro_n   = 1'b1;
            estado_n = FIM;
          end else begin
            hi_n     = sonda_r - UM;
            sonda_n  = meio(lo, sonda_r - UM);
            estado_n = SONDA;
          end
        end else begin
          if (sonda_r == hi) begin
            erro_n   = 1'b1;
            estado_n = FIM;
          end else begin
            lo_n     = sonda_r + UM;
            sonda_n  = meio(sonda_r + UM, hi);
            estado_n = SONDA;
          end
        end
      end

      FIM: begin
        estado_n = OCIOSO;
      end

      default: begin
        estado_n = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado     <= OCIOSO;
      lo         <= '0;
      hi         <= '1;
      sonda_r    <= '0;
      resultado  <= '0;
      passos     <= 4'd0;
      encontrado <= 1'b0;
      erro       <= 1'b0;
      f_gt       <= 1'b0;
      f_eq       <= 1'b0;
      f_lt       <= 1'b0;
    end else begin
      estado     <= estado_n;
      lo         <= lo_n;
      hi         <= hi_n;
      sonda_r    <= sonda_n;
      resultado  <= resultado_n;
      passos     <= passos_n;
      encontrado <= encontrado_n;
      erro       <= erro_n;
      f_gt       <= f_gt_n;
      f_eq       <= f_eq_n;
      f_lt       <= f_lt_n;
    end
  end

  assign bus.sonda        = sonda_r;
  assign bus.sonda_valida = (estado == SONDA);
  assign ocupado          = (estado == SONDA) || (estado == ATUALIZA);
  assign pronto           = (estado == FIM);

endmodule
